// File: rtl/dds_mod_ctrl.sv
// DDS modulation controller: symbol-rate LFSR data source, FSK phase-increment
// steering and ASK/FSK/BPSK/LFSR sample modulation of the generator carriers.
module dds_mod_ctrl #(
  parameter int unsigned TICK_DIV  = 50_000_000,
  parameter logic [4:0]  LFSR_SEED = 5'b00001
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        en_i,
  input  logic [1:0]  mod_sel_i,
  input  logic [1:0]  sig_sel_i,
  input  logic [11:0] sin_i,
  input  logic [11:0] cos_i,
  input  logic [11:0] squ_i,
  input  logic [11:0] saw_i,
  input  logic [31:0] phase_inc_base_i,
  input  logic [31:0] phase_inc_alt_i,
  output logic [31:0] phase_inc_o,
  output logic [11:0] mod_o,
  output logic        mod_valid_o,
  output logic [4:0]  lfsr_o,
  output logic        lfsr_bit_o
);

  localparam int          CW      = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST  = CW'(TICK_DIV - 1);
  localparam logic [4:0]  SEED    = (LFSR_SEED == 5'd0) ? 5'd1 : LFSR_SEED;
  localparam logic [11:0] POS_MAX = 12'h7FF;
  localparam logic [11:0] NEG_MAX = 12'h800;

  logic [CW-1:0] divCnt_q, divCnt_d;
  logic [4:0]    lfsr_q, lfsr_d;
  logic [11:0]   modOut_q, modOut_d;
  logic          modValid_q, modValid_d;
  logic [31:0]   phaseInc_q, phaseInc_d;
  logic          step;
  logic [11:0]   carrier, negCarrier, sample;

  // Divider and LFSR advance; the divider ignores en so the symbol rate is fixed.
  always_comb begin
    step     = (divCnt_q == LAST);
    divCnt_d = step ? '0 : divCnt_q + CW'(1);
    lfsr_d   = step ? {lfsr_q[3:0], lfsr_q[4] ^ lfsr_q[2]} : lfsr_q;
  end

  always_comb begin
    unique case (sig_sel_i)
      2'b00:   carrier = sin_i;
      2'b01:   carrier = cos_i;
      2'b10:   carrier = squ_i;
      default: carrier = saw_i;
    endcase
    // -2048 has no positive counterpart in 12 bits, so it clamps to +2047.
    negCarrier = (carrier == NEG_MAX) ? POS_MAX : (~carrier + 12'd1);

    unique case (mod_sel_i)
      2'b00:   sample = lfsr_q[0] ? carrier : 12'd0;
      2'b01:   sample = sin_i;
      2'b10:   sample = lfsr_q[0] ? carrier : negCarrier;
      default: sample = lfsr_q[0] ? POS_MAX : NEG_MAX;
    endcase

    modOut_d   = en_i ? sample : modOut_q;
    modValid_d = en_i;
    phaseInc_d = ((mod_sel_i == 2'b01) && lfsr_q[0]) ? phase_inc_alt_i : phase_inc_base_i;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      divCnt_q   <= '0;
      lfsr_q     <= SEED;
      modOut_q   <= '0;
      modValid_q <= 1'b0;
      phaseInc_q <= '0;
    end else begin
      divCnt_q   <= divCnt_d;
      lfsr_q     <= lfsr_d;
      modOut_q   <= modOut_d;
      modValid_q <= modValid_d;
      phaseInc_q <= phaseInc_d;
    end
  end

  assign phase_inc_o = phaseInc_q;
  assign mod_o       = modOut_q;
  assign mod_valid_o = modValid_q;
  assign lfsr_o      = lfsr_q;
  assign lfsr_bit_o  = lfsr_q[0];

endmodule

// File: tb/tb_dds_mod_ctrl.sv
// Self-checking bench for dds_mod_ctrl: a closed-form reference (LFSR state from
// elapsed symbol count, sample rules from the modulation table) checked every cycle.
module tb_dds_mod_ctrl;

   localparam int TD = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        en = 1'b0;
   logic [1:0]  modSel = 2'd0;
   logic [1:0]  sigSel = 2'd0;
   logic [11:0] sinIn = '0, cosIn = '0, squIn = '0, sawIn = '0;
   logic [31:0] phaseBase = '0, phaseAlt = '0;
   logic [31:0] phaseInc;
   logic [11:0] modOut;
   logic        modValid;
   logic [4:0]  lfsrOut;
   logic        lfsrBit;

   int          nCompared = 0;
   int          nMismatched = 0;
   bit          checking = 1'b0;
   logic [4:0]  seq [0:30];
   int          edgeCount = 0;
   int          expMod = 0;
   bit          expValid = 1'b0;
   logic [31:0] expPhase = '0;

   dds_mod_ctrl #(.TICK_DIV(TD), .LFSR_SEED(5'b00001)) dut (
      .clk_i            (clk),
      .reset_i          (reset),
      .en_i             (en),
      .mod_sel_i        (modSel),
      .sig_sel_i        (sigSel),
      .sin_i            (sinIn),
      .cos_i            (cosIn),
      .squ_i            (squIn),
      .saw_i            (sawIn),
      .phase_inc_base_i (phaseBase),
      .phase_inc_alt_i  (phaseAlt),
      .phase_inc_o      (phaseInc),
      .mod_o            (modOut),
      .mod_valid_o      (modValid),
      .lfsr_o           (lfsrOut),
      .lfsr_bit_o       (lfsrBit)
   );

   always #5 clk = ~clk;

   function automatic int toInt(logic [11:0] v);
      return int'($signed(v));
   endfunction

   // Data bit in force after e clock edges: one LFSR step per TD edges, period 31.
   function automatic int modelBit(int e);
      return int'(seq[(e / TD) % 31][0]);
   endfunction

   function automatic int negSat(int v);
      return (v == -2048) ? 2047 : -v;
   endfunction

   function automatic int pickCarrier(logic [1:0] s);
      case (s)
         2'd0:    return toInt(sinIn);
         2'd1:    return toInt(cosIn);
         2'd2:    return toInt(squIn);
         default: return toInt(sawIn);
      endcase
   endfunction

   function automatic int modelSample(int b);
      case (modSel)
         2'd0:    return (b == 1) ? pickCarrier(sigSel) : 0;
         2'd1:    return toInt(sinIn);
         2'd2:    return (b == 1) ? pickCarrier(sigSel) : negSat(pickCarrier(sigSel));
         default: return (b == 1) ? 2047 : -2048;
      endcase
   endfunction

   function automatic logic [11:0] randCarrier();
      if ($urandom_range(0, 7) == 0) return 12'h800;
      return 12'($urandom);
   endfunction

   task automatic checkOutput(string name, longint actual, longint expected);
      nCompared++;
      if (actual != expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(bit e, logic [1:0] m, logic [1:0] s,
                                logic [11:0] si, logic [11:0] co,
                                logic [11:0] sq, logic [11:0] sa);
      en = e; modSel = m; sigSel = s;
      sinIn = si; cosIn = co; squIn = sq; sawIn = sa;
   endtask

   task automatic applyRandom(int enPct);
      applyStimulus($urandom_range(0, 99) < enPct, 2'($urandom), 2'($urandom),
                    randCarrier(), randCarrier(), randCarrier(), randCarrier());
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic waitBit(int val);
      int n = 0;
      while (modelBit(edgeCount) != val && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) checkOutput("waitBitTimeout", 0, 1);
   endtask

   // Reference model: advances on the same edges as the DUT, from spec-level rules.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         edgeCount <= 0;
         expMod    <= 0;
         expValid  <= 1'b0;
         expPhase  <= '0;
      end else begin
         if (en) expMod <= modelSample(modelBit(edgeCount));
         expValid  <= en;
         expPhase  <= (modSel == 2'd1 && modelBit(edgeCount) == 1) ? phaseAlt : phaseBase;
         edgeCount <= edgeCount + 1;
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      if (checking) begin
         checkOutput("lfsr", lfsrOut, seq[(edgeCount / TD) % 31]);
         checkOutput("lfsrBit", lfsrBit, modelBit(edgeCount));
         checkOutput("lfsrNonZero", longint'(lfsrOut != 5'd0), 1);
         checkOutput("modOut", toInt(modOut), expMod);
         checkOutput("modValid", modValid, expValid);
         checkOutput("phaseInc", phaseInc, expPhase);
      end
   end

   // Directed scenarios first, then randomized traffic with resets.
   initial begin
      int zeros;
      logic [4:0] wrapNext;
      bit found;

      seq[0] = 5'b00001;
      for (int i = 1; i < 31; i++)
         seq[i] = {seq[i-1][3:0], seq[i-1][4] ^ seq[i-1][2]};
      zeros = 0;
      for (int i = 0; i < 31; i++) if (seq[i] == 5'd0) zeros++;
      wrapNext = {seq[30][3:0], seq[30][4] ^ seq[30][2]};
      checkOutput("seqZeros", zeros, 0);
      checkOutput("seqWrap", wrapNext, 5'b00001);

      #1 reset = 1'b1;
      repeat (3) tick();
      checking = 1'b1;
      checkOutput("rstLfsr", lfsrOut, 5'b00001);
      checkOutput("rstMod", toInt(modOut), 0);
      checkOutput("rstValid", modValid, 0);
      checkOutput("rstPhase", phaseInc, 0);
      reset = 1'b0;

      // LFSR walk, with LFSR-waveform samples near the end so mod_out is nonzero.
      for (int i = 1; i <= 130; i++) begin
         if (i == 125) applyStimulus(1'b1, 2'd3, 2'd0, '0, '0, '0, '0);
         tick();
         if (i == 4)   checkOutput("lfsrStep1", lfsrOut, 5'b00010);
         if (i == 8)   checkOutput("lfsrStep2", lfsrOut, 5'b00100);
         if (i == 12)  checkOutput("lfsrStep3", lfsrOut, 5'b01001);
         if (i == 123) checkOutput("lfsrStep30", lfsrOut, 5'b10000);
         if (i == 124) checkOutput("lfsrStep31", lfsrOut, 5'b00001);
      end
      checkOutput("preRstModNonZero", longint'(modOut != 12'd0), 1);

      #2 reset = 1'b1;
      #1;
      checkOutput("midRstLfsr", lfsrOut, 5'b00001);
      checkOutput("midRstMod", toInt(modOut), 0);
      checkOutput("midRstValid", modValid, 0);
      applyStimulus(1'b0, 2'd0, 2'd0, '0, '0, '0, '0);
      tick();
      reset = 1'b0;
      repeat (3) tick();
      checkOutput("postRstNoStep", lfsrOut, 5'b00001);
      tick();
      checkOutput("postRstStep", lfsrOut, 5'b00010);

      // ASK / BPSK directed samples
      waitBit(1);
      applyStimulus(1'b1, 2'd0, 2'd0, 12'd300, '0, '0, '0);
      tick();
      checkOutput("askOne", toInt(modOut), 300);
      checkOutput("askOneValid", modValid, 1);
      en = 1'b0;
      tick();
      checkOutput("validDrop", modValid, 0);
      waitBit(1);
      applyStimulus(1'b1, 2'd2, 2'd0, 12'd300, '0, '0, '0);
      tick();
      checkOutput("bpskOne", toInt(modOut), 300);
      en = 1'b0;
      waitBit(0);
      applyStimulus(1'b1, 2'd0, 2'd0, 12'd300, '0, '0, '0);
      tick();
      checkOutput("askZero", toInt(modOut), 0);
      en = 1'b0;
      waitBit(0);
      applyStimulus(1'b1, 2'd2, 2'd0, 12'd300, '0, '0, '0);
      tick();
      checkOutput("bpskNeg", toInt(modOut), -300);
      en = 1'b0;
      waitBit(0);
      applyStimulus(1'b1, 2'd2, 2'd0, 12'h800, '0, '0, '0);
      tick();
      checkOutput("bpskSat", toInt(modOut), 2047);
      en = 1'b0;

      // FSK phase steering
      phaseBase = 32'h0000_1000;
      phaseAlt  = 32'h0000_2000;
      applyStimulus(1'b0, 2'd1, 2'd0, 12'd5, '0, '0, '0);
      waitBit(1);
      tick();
      checkOutput("fskAlt", phaseInc, 32'h0000_2000);
      waitBit(0);
      tick();
      checkOutput("fskBase", phaseInc, 32'h0000_1000);
      for (int i = 0; i < 40; i++) begin
         en = 1'($urandom_range(0, 1));
         sinIn = randCarrier();
         tick();
      end
      waitBit(1);
      modSel = 2'd0;
      tick();
      checkOutput("fskOff", phaseInc, 32'h0000_1000);

      // LFSR as waveform, en held high
      for (int i = 0; i < 60; i++) begin
         applyStimulus(1'b1, 2'd3, 2'($urandom), randCarrier(), randCarrier(), randCarrier(), randCarrier());
         tick();
         checkOutput("enHighValid", modValid, 1);
      end

      // en coinciding with a step that turns the data bit from 1 to 0
      en = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 400 && !found; i++) begin
         if (edgeCount % TD == TD - 1 && modelBit(edgeCount) == 1 && modelBit(edgeCount + 1) == 0)
            found = 1'b1;
         else
            tick();
      end
      if (!found) checkOutput("enStepTimeout", 0, 1);
      applyStimulus(1'b1, 2'd0, 2'd1, 12'd77, 12'hFFB, 12'd9, 12'd11);
      tick();
      checkOutput("enStepMod", toInt(modOut), -5);
      checkOutput("enStepBit", lfsrBit, 0);

      // Hold: en low while carriers and selects change
      applyStimulus(1'b1, 2'd3, 2'd0, '0, '0, '0, '0);
      tick();
      for (int i = 0; i < 20; i++) begin
         applyRandom(0);
         tick();
         checkOutput("holdValid", modValid, 0);
      end

      // Randomized traffic
      for (int i = 0; i < 2000; i++) begin
         if (i % 250 == 0) begin
            phaseBase = $urandom;
            phaseAlt  = $urandom;
         end
         applyRandom((i / 500) % 2 == 0 ? 50 : 90);
         tick();
      end

      // Reset at an arbitrary point in a symbol
      #3 reset = 1'b1;
      #1;
      checkOutput("randRstLfsr", lfsrOut, 5'b00001);
      checkOutput("randRstMod", toInt(modOut), 0);
      checkOutput("randRstPhase", phaseInc, 0);
      tick();
      reset = 1'b0;
      for (int i = 0; i < 40; i++) begin
         applyRandom(60);
         tick();
      end

      checking = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/dds_mod_ctrl.md
# dds_mod_ctrl

Modulation controller for the lab 5 DDS chain. It sits on both sides of the waveform generator:
- Upstream, it drives the generator's `phase_inc` (FSK frequency switching).
- Downstream, it consumes the generator's four 12-bit carrier outputs and produces one modulated sample stream (ASK, FSK, BPSK or raw LFSR).

A 5-bit LFSR provides the pseudo-random data bit. A free-running divider steps the LFSR at the symbol rate.

## Interface
Parameters:
- `TICK_DIV`, 50_000_000, clk cycles per LFSR step (symbol period); legal range ≥ 2.
- `LFSR_SEED`, 5'b00001, LFSR reset value; a value of 0 is replaced by 5'b00001.

Ports:
- `clk`  in  1  system clock; only clock of the block.
- `reset`  in  1  asynchronous, active-high reset.
- `en`  in  1  sample strobe; the same strobe that enables the waveform generator.
- `mod_sel`  in  2  00 ASK, 01 FSK, 10 BPSK, 11 LFSR-as-waveform.
- `sig_sel`  in  2  carrier for ASK/BPSK: 00 sin, 01 cos, 10 squ, 11 saw.
- `sin_in`, `cos_in`, `squ_in`, `saw_in`  in  12 each  generator outputs, signed two's complement.
- `phase_inc_base`  in  32  phase increment for data bit 0.
- `phase_inc_alt`  in  32  phase increment for data bit 1 (FSK only).
- `phase_inc_out`  out  32  registered, drives the generator's `phase_inc`.
- `mod_out`  out  12  registered modulated sample, signed.
- `mod_valid`  out  1  one-cycle pulse, high when `mod_out` is updated.
- `lfsr_out`  out  5  current LFSR state.
- `lfsr_bit`  out  1  data bit, equal to `lfsr_out[0]`.

## Operation
Symbol divider:
- Counter runs 0..`TICK_DIV`-1 every clk, independent of `en`.
- Internal `step` asserts on the cycle the counter equals `TICK_DIV`-1; the counter then wraps to 0.

LFSR:
- Fibonacci, polynomial x^5+x^3+1.
- On `step`, next = {q[3:0], q[4]^q[2]}.
- Maximal length: 31 states; it never reaches 0 from a nonzero seed.

Sample path (on `en`=1), `mod_out` is loaded with:
- ASK: carrier selected by `sig_sel` if `lfsr_bit`=1, else 0.
- FSK: `sin_in`, regardless of `sig_sel`.
- BPSK: selected carrier if `lfsr_bit`=1, else its two's-complement negation. Negating -2048 saturates to +2047.
- LFSR: +2047 if `lfsr_bit`=1, else -2048.

`mod_valid` is registered from `en`. Other rules:
- `en`=0: `mod_out` holds its value and `mod_valid`=0.
- `mod_sel` and `sig_sel` are sampled only on `en` cycles; changes take effect at the next `en`.

Phase path (every cycle):
- `phase_inc_out` <= `phase_inc_alt` when `mod_sel`=01 and `lfsr_bit`=1, else `phase_inc_base`.
- Not gated by `en`.

## Timing
Reset (asynchronous assert, released synchronously by the system):
- `lfsr_out` = seed; `lfsr_bit` = seed[0].
- Divider = 0.
- `mod_out` = 0, `mod_valid` = 0, `phase_inc_out` = 0.

Latencies:
- `mod_out` / `mod_valid`: 1 clk after the `en` cycle.
- First `step` occurs `TICK_DIV` clks after reset release (counter reaches `TICK_DIV`-1 on clk `TICK_DIV`).
- `lfsr_out`: 1 clk after `step`.
- `phase_inc_out`: 1 clk after the `lfsr_bit` / `mod_sel` change, so 2 clks after `step`. The first valid `phase_inc_out` appears 1 clk after reset release.

Boundary conditions:
- `en` and `step` in the same cycle: `mod_out` uses the pre-step `lfsr_bit`.
- `en` held high continuously: `mod_out` updates every cycle; `mod_valid` stays high.
- Divider wrap: no cycle is skipped or duplicated; step spacing is exactly `TICK_DIV` clks.
- Reset mid-symbol: all state returns to reset values immediately. The divider restarts, so the next `step` comes `TICK_DIV` clks after release.
- Arithmetic: all sample arithmetic is 12-bit signed with saturation only at the -2048 negation; there is no other overflow case.

## Test plan
- Reset/LFSR sequence. TICK_DIV=4, seed 00001, run 130 clks after reset. Required: `lfsr_out` steps every 4 clks through 00001 → 00010 → 00100 → 01001 → …, returns to 00001 after 31 steps, and is never 0. Assert `reset` mid-run: `lfsr_out` returns to 00001 and `mod_out` to 0 in the same cycle.
- ASK/BPSK. `sig_sel`=00, `sin_in`=300, `en` pulsed once.
  - `lfsr_bit`=1 → `mod_out`=300 with `mod_valid` 1 clk later.
  - `lfsr_bit`=0 → ASK gives 0, BPSK gives -300.
  - BPSK with `lfsr_bit`=0 and `sin_in`=-2048 → +2047.
- FSK phase. `mod_sel`=01, base=0x0000_1000, alt=0x0000_2000. Required: `phase_inc_out` toggles between base and alt 2 clks after each `step` that flips `lfsr_bit`. Switch `mod_sel`=00: `phase_inc_out`=base on the next clk.
- LFSR waveform. `mod_sel`=11, `en` every cycle. Required: `mod_out` alternates between +2047 and -2048 exactly following `lfsr_bit`, with 1 clk lag.
- Simultaneous `en`+`step`. Force `lfsr_bit`=1 before a `step` that makes it 0, with ASK and `cos_in`=-5. Required: `mod_out`=-5, i.e. the old bit is used.
- Hold. `en`=0 for 20 clks while carriers change. Required: `mod_out` is constant and `mod_valid`=0.
